// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: one request/ready handshake carrying a
// word address, byte enables and lane-replicated write data.
interface load_store_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into a single bus transaction, with
// alignment checking, byte-lane steering, load extension and a bus timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              timeout_o,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  // Counter value at which the next unanswered cycle would reach the limit.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [7:0]  wait_cnt_reg;
  logic        timeout_reg;

  logic        req_bad;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] load_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [7:0]  rd_byte [4];

  always_comb begin
    req_bad = 1'b0;
    case (funct3_i)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = addr_i[0];
      3'b010:         req_bad = |addr_i[1:0];
      default:        req_bad = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (we_i && funct3_i[2]) req_bad = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_i) state_next = req_bad ? ERR : BUS;
      BUS: begin
        if (mem.mem_ready_i)                  state_next = DONE;
        else if (wait_cnt_reg == TIMEOUT_LAST) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      funct3_reg   <= 3'b000;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      rdata_reg    <= 32'h0;
      wait_cnt_reg <= 8'h0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_i) begin
        we_reg       <= we_i;
        funct3_reg   <= funct3_i;
        addr_reg     <= addr_i;
        wdata_reg    <= wdata_i;
        wait_cnt_reg <= 8'h0;
        timeout_reg  <= 1'b0;
      end
      if (state_reg == BUS) begin
        if (!mem.mem_ready_i) wait_cnt_reg <= wait_cnt_reg + 8'h1;
        if (mem.mem_ready_i && !we_reg) rdata_reg <= load_val;
        timeout_reg <= !mem.mem_ready_i && (wait_cnt_reg == TIMEOUT_LAST);
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign rd_byte[gi] = mem.mem_rdata_i[8*gi +: 8];
    assign be[gi] = (funct3_reg[1:0] == 2'b10) ||
                    (funct3_reg[1:0] == 2'b01 && addr_reg[1] == LANE[1]) ||
                    (funct3_reg[1:0] == 2'b00 && addr_reg[1:0] == LANE);
  end

  always_comb begin
    lane_b = rd_byte[addr_reg[1:0]];
    lane_h = addr_reg[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (funct3_reg[1:0])
      2'b00:   load_val = {{24{lane_b[7] & ~funct3_reg[2]}}, lane_b};
      2'b01:   load_val = {{16{lane_h[15] & ~funct3_reg[2]}}, lane_h};
      default: load_val = mem.mem_rdata_i;
    endcase
  end

  always_comb begin
    case (funct3_reg[1:0])
      2'b00:   wdata_rep = {4{wdata_reg[7:0]}};
      2'b01:   wdata_rep = {2{wdata_reg[15:0]}};
      default: wdata_rep = wdata_reg;
    endcase
  end

  // Bus outputs are forced to zero outside BUS so the memory side sees a clean idle bus.
  assign mem.mem_req_o   = (state_reg == BUS);
  assign mem.mem_we_o    = (state_reg == BUS) && we_reg;
  assign mem.mem_addr_o  = (state_reg == BUS) ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem.mem_be_o    = (state_reg == BUS) ? be : 4'h0;
  assign mem.mem_wdata_o = (state_reg == BUS && we_reg) ? wdata_rep : 32'h0;

  assign busy_o     = (state_reg == BUS) || (state_reg == IDLE && req_i);
  assign done_o     = (state_reg == DONE);
  assign misalign_o = (state_reg == ERR) && !timeout_reg;
  assign timeout_o  = (state_reg == ERR) && timeout_reg;
  assign rdata_o    = rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level model predicts every
// output each cycle; directed cases pin the model with literal values.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misalign_o, timeout_o;
  logic [31:0] rdata_o;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o), .mem(bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_done = 0, n_to = 0, n_req = 0, done_cyc = 0, mis_cyc = 0, acc_cyc = 0;
  bit check_en = 0;
  logic [31:0] model_rdata = 0;
  logic        e_busy, e_done, e_mis, e_to, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  logic [31:0] l_addr, l_wdata;
  logic [3:0]  l_be;
  logic        l_we;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---- behavioural model ----
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
    if (we && f3 >= 4) return 1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << m_size(f3)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int sz;
    logic [31:0] v, mask;
    sz = m_size(f3);
    if (sz == 4) return d;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (d >> (8 * (a % 4))) & mask;
    if (f3 < 4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  // ---- per-cycle compare ----
  always @(negedge clk_i) begin
    if (check_en) begin
      chk("busy_o", busy_o, e_busy);
      chk("done_o", done_o, e_done);
      chk("misalign_o", misalign_o, e_mis);
      chk("timeout_o", timeout_o, e_to);
      chk("rdata_o", rdata_o, e_rdata);
      chk("mem_req_o", bus.mem_req_o, e_req);
      chk("mem_we_o", bus.mem_we_o, e_we);
      chk("mem_addr_o", bus.mem_addr_o, e_addr);
      chk("mem_be_o", bus.mem_be_o, e_be);
      chk("mem_wdata_o", bus.mem_wdata_o, e_wdata);
      if (done_o) begin n_done++; done_cyc = cyc; end
      if (misalign_o) mis_cyc = cyc;
      if (timeout_o) n_to++;
      if (bus.mem_req_o) begin
        n_req++;
        l_addr = bus.mem_addr_o; l_be = bus.mem_be_o;
        l_wdata = bus.mem_wdata_o; l_we = bus.mem_we_o;
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_exp_idle(input bit busy);
    e_busy = busy; e_done = 0; e_mis = 0; e_to = 0; e_req = 0; e_we = 0;
    e_addr = 0; e_be = 0; e_wdata = 0; e_rdata = model_rdata;
  endtask

  task automatic set_exp_bus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] w);
    set_exp_idle(1);
    e_req = 1; e_we = we; e_addr = a & 32'hFFFF_FFFC; e_be = m_be(f3, a);
    e_wdata = we ? m_wd(f3, w) : 32'h0;
  endtask

  task automatic scramble_core;
    req_i = 1'($urandom); we_i = 1'($urandom); funct3_i = 3'($urandom);
    addr_i = $urandom; wdata_i = $urandom;
  endtask

  // One core access; delay = index of the BUS cycle that sees mem_ready_i (>=T -> timeout).
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] rd, input int delay);
    bit fin;
    fin = 0;
    req_i = 1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = w;
    bus.mem_ready_i = 1'($urandom); bus.mem_rdata_i = $urandom;
    set_exp_idle(1);
    acc_cyc = cyc;
    tick;
    scramble_core;
    if (m_bad(we, f3, a)) begin
      set_exp_idle(0); e_mis = 1;
      bus.mem_ready_i = 1'($urandom);
      tick;
    end else begin
      for (int i = 0; i < T && !fin; i++) begin
        bus.mem_ready_i = (i == delay);
        bus.mem_rdata_i = (i == delay) ? rd : $urandom;
        set_exp_bus(we, f3, a, w);
        tick;
        if (i == delay) begin
          if (!we) model_rdata = m_ld(f3, a, rd);
          set_exp_idle(0); e_done = 1;
          bus.mem_ready_i = 1'($urandom);
          tick;
          fin = 1;
        end
      end
      if (!fin) begin
        set_exp_idle(0); e_to = 1;
        bus.mem_ready_i = 1'($urandom);
        tick;
      end
    end
    req_i = 0;
    set_exp_idle(0);
    tick;
    $display("txn we=%0d f3=%0d addr=%h wdata=%h delay=%0d rdata_o=%h", we, f3, a, w, delay, rdata_o);
  endtask

  int          snap_req, snap_to, snap_done;
  bit          r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;

  initial begin
    rst_i = 1; req_i = 0; we_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    bus.mem_ready_i = 0; bus.mem_rdata_i = 0;
    set_exp_idle(0);
    tick;
    check_en = 1;
    tick;
    rst_i = 0;
    tick;
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_busy", busy_o, 1'b0);

    // LB from the top byte lane, ready on the first BUS cycle.
    do_txn(0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0);
    chk("lb_be", l_be, 4'b1000);
    chk("lb_latency", done_cyc - acc_cyc, 2);
    chk("lb_rdata", rdata_o, 32'hFFFFFF80);

    // SH to the upper half.
    do_txn(1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 2);
    chk("sh_addr", l_addr, 32'h2000);
    chk("sh_be", l_be, 4'b1100);
    chk("sh_wdata", l_wdata, 32'hABCDABCD);
    chk("sh_we", l_we, 1'b1);
    chk("sh_rdata_held", rdata_o, 32'hFFFFFF80);

    // Misaligned LW: error pulse one cycle after acceptance, no bus request.
    snap_req = n_req;
    do_txn(0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
    chk("lw_mis_cycle", mis_cyc - acc_cyc, 1);
    chk("lw_mis_noreq", n_req - snap_req, 0);
    chk("lw_mis_rdata", rdata_o, 32'hFFFFFF80);

    // LHU with no response: exactly T request cycles, one timeout pulse.
    snap_req = n_req; snap_to = n_to;
    do_txn(0, 3'b101, 32'h4002, 32'h0, 32'h0, 100);
    chk("lhu_to_pulses", n_to - snap_to, 1);
    chk("lhu_to_reqcycles", n_req - snap_req, T);
    chk("lhu_to_busy", busy_o, 1'b0);
    chk("lhu_to_rdata", rdata_o, 32'hFFFFFF80);

    // Ready arriving on the last permitted cycle completes instead of timing out.
    snap_to = n_to;
    do_txn(0, 3'b100, 32'h5001, 32'h0, 32'h0000F700, T - 1);
    chk("edge_no_timeout", n_to - snap_to, 0);
    chk("edge_rdata", rdata_o, 32'h000000F7);

    // Reset in the second BUS cycle of an LW.
    snap_done = n_done;
    req_i = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h3000; wdata_i = 0;
    bus.mem_ready_i = 0;
    set_exp_idle(1);
    tick;
    req_i = 0;
    set_exp_bus(0, 3'b010, 32'h3000, 32'h0);
    tick;
    rst_i = 1;
    tick;
    rst_i = 0;
    model_rdata = 0;
    set_exp_idle(0);
    tick;
    chk("rst_bus_req", bus.mem_req_o, 1'b0);
    chk("rst_bus_rdata", rdata_o, 32'h0);
    chk("rst_bus_nodone", n_done - snap_done, 0);
    $display("txn reset during LW bus phase rdata_o=%h", rdata_o);

    for (int n = 0; n < 300; n++) begin
      r_we = 1'($urandom);
      r_f3 = 3'($urandom);
      r_addr = $urandom;
      if ($urandom % 4 != 0) begin
        if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        else if (r_f3[1:0] != 2'b00) r_addr[1:0] = 2'b00;
      end
      do_txn(r_we, r_f3, r_addr, $urandom, $urandom, $urandom_range(0, 5));
    end

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the max cycles waiting for mem_ready_i (legal 1-255).
REQ-002 SHALL have ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- req_i  in  1  core access request, sampled in IDLE.
- we_i  in  1  1=store, 0=load.
- funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data (rs2).
- busy_o  out  1  core stall.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result, feeds writeback result mux input 1.
- misalign_o  out  1  one-cycle error pulse (misaligned/illegal).
- timeout_o  out  1  one-cycle error pulse (bus timeout).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  32  word address, bits [1:0]=00.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables.
- mem_ready_i  in  1  bus accept/response strobe.
- mem_rdata_i  in  32  bus read word, valid when mem_ready_i=1.

Function
REQ-003 SHALL implement FSM states IDLE, BUS, DONE, ERR.
REQ-004 In IDLE with req_i=1, SHALL register we_i, funct3_i, addr_i, wdata_i; go to ERR if illegal/misaligned, else BUS.
REQ-005 Illegal: funct3 in {011,110,111}, or store with funct3[2]=1; misaligned: H/HU with addr[0]=1, W with addr[1:0]!=00.
REQ-006 In BUS, mem_req_o=1 with mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o held stable until mem_ready_i=1 is sampled; then go to DONE.
REQ-007 Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111; loads drive the same pattern.
REQ-008 Store data: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata; mem_wdata_o=0 for loads.
REQ-009 On load completion, SHALL register rdata_o from lane addr[1:0]: B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-010 rdata_o SHALL hold its value until the next load completes; stores and errors do not change it.
REQ-011 DONE: done_o=1 for exactly one cycle, then IDLE; req_i ignored in DONE.
REQ-012 ERR: misalign_o or timeout_o=1 for one cycle, done_o=0, no bus request issued, then IDLE.
REQ-013 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle with mem_ready_i=0; on reaching TIMEOUT_CYCLES, SHALL deassert mem_req_o next cycle and go to ERR with timeout_o.
REQ-014 If mem_ready_i=1 in the cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win over timeout.
REQ-015 busy_o SHALL be 1 in BUS, and in IDLE when req_i=1; 0 in DONE, ERR and idle-without-request.
REQ-016 Latency: req_i accepted at cycle N, mem_req_o high from N+1, mem_ready_i at N+k -> done_o at N+k+1; min 2 cycles.
REQ-017 mem_ready_i outside BUS SHALL be ignored.

Reset
REQ-018 On rst_i=1 at a clock edge, SHALL enter IDLE, clear counter and captured fields; all outputs incl. rdata_o 0.
REQ-019 Reset during BUS SHALL drop mem_req_o the following cycle with no done_o or error pulse.

Verification
REQ-020 LB addr=0x1003, mem_rdata_i=0x80AABBCC, ready on first BUS cycle -> mem_be_o=1000, done_o at N+2, rdata_o=0xFFFFFF80.
REQ-021 SH addr=0x2002, wdata_i=0x1234ABCD -> mem_addr_o=0x2000, mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1.
REQ-022 LW addr=0x3001 -> misalign_o pulse at N+1, mem_req_o never 1, rdata_o unchanged.
REQ-023 TIMEOUT_CYCLES=4, LHU with mem_ready_i held 0 -> timeout_o pulse once, mem_req_o low after 4 BUS cycles, busy_o released.
REQ-024 rst_i asserted in second BUS cycle of LW -> next cycle state IDLE, mem_req_o=0, rdata_o=0, no done_o.
